// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Issues one instruction-memory request at a time
// from the PC register, captures the returned word together with PC+4 and
// presents both to the IF/ID pipeline register. Redirects (taken branches and
// jumps) flush IF/ID and restart fetch at the word-aligned target. Any
// response that belongs to a request made before the redirect is discarded.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   When defined, a response that arrives while IF/ID can accept it is
//   forwarded combinationally in the response cycle. This skips the hold
//   state, so one instruction is delivered every two cycles instead of three.
//   When undefined, every instruction is registered and presented from the
//   hold state.
//
// Parameters:
//   LENGTH    datapath width (default 32)
//   RESET_PC  first fetch address after reset (default 32'h0000_3000)
//
// Ports:
//   clk                clock, all state updates on the rising edge
//   rst                synchronous active-high reset
//   stall_i            IF/ID cannot accept this cycle
//   redirect_i         branch/jump taken, restart fetch at redirect_pc_i
//   redirect_pc_i      redirect target (low two bits ignored)
//   imem_req_valid_o   instruction-memory request valid
//   imem_req_ready_i   memory accepts the request this cycle
//   imem_req_addr_o    fetch address (always the PC register)
//   imem_resp_valid_i  instruction data valid this cycle
//   imem_resp_data_i   returned instruction word
//   instr_o            instruction toward IF/ID
//   pc_4_o             fetched PC + 4 toward IF/ID
//   if_id_wen_o        IF/ID write enable (instr_o/pc_4_o valid and accepted)
//   if_id_flush_o      IF/ID flush, high only in redirect cycles
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned       LENGTH   = 32,
  parameter logic [LENGTH-1:0] RESET_PC = LENGTH'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [LENGTH-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [LENGTH-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [LENGTH-1:0] imem_resp_data_i,
  output logic [LENGTH-1:0] instr_o,
  output logic [LENGTH-1:0] pc_4_o,
  output logic              if_id_wen_o,
  output logic              if_id_flush_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] pc_q, pc_d;
  logic [LENGTH-1:0] instr_q, instr_d;
  logic [LENGTH-1:0] pc4_q, pc4_d;
  logic              drop_q, drop_d;

  logic [LENGTH-1:0] pc_plus4;
  logic [LENGTH-1:0] redirect_target;
  logic              bypass;

  // Wraps naturally modulo 2^LENGTH.
  assign pc_plus4        = pc_q + LENGTH'(4);
  assign redirect_target = {redirect_pc_i[LENGTH-1:2], 2'b00};

`ifdef FETCH_BYPASS_EN
  // A live response that IF/ID can take right now goes straight through.
  assign bypass = !rst && (state_q == S_WAIT) && imem_resp_valid_i &&
                  !drop_q && !stall_i && !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  // Outputs are gated by rst so that nothing leaves the unit during the
  // reset cycle even though the state registers still hold old values.
  assign imem_req_addr_o  = pc_q;
  assign imem_req_valid_o = !rst && (state_q == S_REQ);
  assign if_id_flush_o    = !rst && redirect_i;
  assign if_id_wen_o      = !rst && !redirect_i &&
                            (((state_q == S_HOLD) && !stall_i) || bypass);
  assign instr_o          = bypass ? imem_resp_data_i : instr_q;
  assign pc_4_o           = bypass ? pc_plus4         : pc4_q;

  // Next-state logic. A redirect overrides every normal transition; the drop
  // flag remembers that the one outstanding request is stale so its response
  // can be swallowed when it eventually arrives.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    drop_d  = drop_q;

    if (redirect_i) begin
      pc_d = redirect_target;
      case (state_q)
        S_REQ: begin
          if (imem_req_ready_i) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_HOLD: begin
          state_d = S_REQ;
        end
        default: begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready_i) begin
            state_d = S_WAIT;
            drop_d  = 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid_i) begin
            if (drop_q) begin
              state_d = S_REQ;
              drop_d  = 1'b0;
            end else if (bypass) begin
              pc_d    = pc_plus4;
              state_d = S_REQ;
            end else begin
              instr_d = imem_resp_data_i;
              pc4_d   = pc_plus4;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      drop_q  <= drop_d;
    end
  end

endmodule
